sum_accumulator_32bit: RTL and testbench
========================================

Name: sum_accumulator_32bit

Overview:
- Downstream stage of the 32-bit adder: consumes a stream of adder sums over a valid/ready handshake and accumulates a programmed number of them into one 32-bit total.
- Flags unsigned overflow and presents the total over a valid/ready output.
- Sits between the combinational adder datapath and any consumer that needs a reduced, registered result.

Parameters:
- DATA_WIDTH, 32, width of incoming sums and of the accumulator.
- COUNT_WIDTH, 8, width of the length field and the internal sample counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new accumulation; accepted only in IDLE.
- cfg_len  input  COUNT_WIDTH  number of sums to accumulate; sampled with start; 0 means 2^COUNT_WIDTH.
- flush  input  1  synchronous abort; returns to IDLE and discards any result.
- in_valid  input  1  in_sum is valid.
- in_ready  output  1  block accepts in_sum this cycle.
- in_sum  input  DATA_WIDTH  sum from the adder.
- out_valid  output  1  out_acc and out_ovf are valid.
- out_ready  input  1  consumer takes the result.
- out_acc  output  DATA_WIDTH  accumulated total, modulo 2^DATA_WIDTH.
- out_ovf  output  1  sticky: at least one accumulation produced a carry out of the MSB.
- busy  output  1  high in ACCUM and DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, acc=0, ovf=0, cnt=0, len_q=0.
  - Outputs go low: in_ready=0, out_valid=0, out_acc=0, out_ovf=0, busy=0.
  - Deassertion is synchronised externally; the block itself acts on the first clk edge after rst_n goes high.
- States: IDLE, ACCUM, DONE. All outputs are decoded from registered state; there is no combinational path from in_* to out_*.
- IDLE:
  - in_ready=0, out_valid=0.
  - On start=1 (and flush=0): len_q<=cfg_len, acc<=0, ovf<=0, cnt<=0, next state ACCUM.
- ACCUM:
  - in_ready=1, busy=1.
  - On the handshake in_valid & in_ready:
    - {carry, acc} <= acc + in_sum, computed at DATA_WIDTH+1 bits.
    - ovf <= ovf | carry.
    - cnt <= cnt+1.
  - If cnt == len_q-1 (modulo 2^COUNT_WIDTH, so len_q=0 completes after 256 beats) on a handshake, next state is DONE.
  - No handshake: hold all state.
- DONE:
  - in_ready=0, out_valid=1; out_acc=acc, out_ovf=ovf, held stable until taken.
  - On out_ready=1: next state IDLE; out_acc/out_ovf keep their last value, but out_valid drops.
- Latency: out_valid rises on the clock edge that accepts the final beat, i.e. the cycle after that beat is presented. Back-to-back beats are accepted every cycle in ACCUM.
- start outside IDLE: ignored; cfg_len is not re-sampled.
- start and out_ready in the same DONE cycle: the result is taken and the block returns to IDLE. That start is ignored; a new start is needed in IDLE.
- flush, any state: next state IDLE, acc=0, ovf=0, cnt=0, out_valid=0 the next cycle.
  - flush wins over start, handshakes and out_ready in the same cycle.
  - A result pending in DONE is lost.
- Wrap-around: acc wraps modulo 2^DATA_WIDTH; out_ovf records that any wrap occurred. The counter never exceeds len_q.
- in_sum is sampled only on handshake; values presented with in_valid=0 or in_ready=0 have no effect.

Test Plan:
- Reset mid-ACCUM: start, cfg_len=4, accept 2 beats, pulse rst_n low -> asynchronously in_ready=0, busy=0, out_valid=0, out_acc=0; the next start begins from a clean accumulator.
- Basic: start with cfg_len=3; in_sum=0x00000010, 0x00000020, 0x00000030 on consecutive cycles -> out_valid one cycle after the third beat; out_acc=0x00000060, out_ovf=0.
- Overflow: cfg_len=2; in_sum=0xFFFFFFF0 then 0x00000020 -> out_acc=0x00000010, out_ovf=1.
- Backpressure and gaps:
  - cfg_len=2 with in_valid gapped, plus out_ready held low 5 cycles -> out_acc/out_valid stable the whole time.
  - The result is consumed on the first out_ready=1 cycle, then IDLE.
- Full length: cfg_len=0, 256 beats of in_sum=1 -> out_valid only after beat 256, out_acc=0x00000100; the 255th beat does not complete the run.
- Flush and ignored start:
  - start during ACCUM with a different cfg_len -> no effect.
  - flush asserted with start in DONE -> IDLE next cycle, out_valid=0, result discarded, busy=0.

Source files
------------

// File: rtl/sum_accumulator_32bit_if.sv
// Valid/ready bundle between the adder stream, the accumulator and its consumer.
// The master side drives the control and input stream; the slave side is the accumulator.
interface sum_accumulator_32bit_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
);
  logic                   start;
  logic [COUNT_WIDTH-1:0] cfg_len;
  logic                   flush;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_WIDTH-1:0]  in_sum;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  out_acc;
  logic                   out_ovf;
  logic                   busy;

  modport master (
    output start, cfg_len, flush, in_valid, in_sum, out_ready,
    input  in_ready, out_valid, out_acc, out_ovf, busy
  );

  modport slave (
    input  start, cfg_len, flush, in_valid, in_sum, out_ready,
    output in_ready, out_valid, out_acc, out_ovf, busy
  );
endinterface

// File: rtl/sum_accumulator_32bit.sv
// Accumulates a programmed number of adder sums into one registered total with a sticky
// unsigned-overflow flag; every output is decoded from registered state only.
module sum_accumulator_32bit #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  sum_accumulator_32bit_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state_r;
  state_t                 state_nx_s;
  logic [DATA_WIDTH-1:0]  acc_r;
  logic                   ovf_r;
  logic [COUNT_WIDTH-1:0] cnt_r;
  logic [COUNT_WIDTH-1:0] len_q_r;

  logic                   beat_s;
  logic                   last_s;
  logic                   carry_s;
  logic [DATA_WIDTH-1:0]  sum_s;

  assign beat_s = bus.in_valid & (state_r == ST_ACCUM);
  // len_q = 0 wraps to all-ones, so a zero length completes after 2^COUNT_WIDTH beats
  assign last_s = (cnt_r == (len_q_r - CNT_ONE));
  assign {carry_s, sum_s} = {1'b0, acc_r} + {1'b0, bus.in_sum};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; flush overrides every other event
  always_comb begin
    state_nx_s = state_r;
    if (bus.flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_nx_s = ST_ACCUM;
          end else begin
            state_nx_s = ST_IDLE;
          end
        end
        ST_ACCUM: begin
          if (beat_s && last_s) begin
            state_nx_s = ST_DONE;
          end else begin
            state_nx_s = ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_DONE;
          end
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // Accumulator datapath: clear on flush, init on accepted start, add on each handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r   <= {DATA_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      cnt_r   <= {COUNT_WIDTH{1'b0}};
      len_q_r <= {COUNT_WIDTH{1'b0}};
    end else if (bus.flush) begin
      acc_r <= {DATA_WIDTH{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {COUNT_WIDTH{1'b0}};
    end else if ((state_r == ST_IDLE) && bus.start) begin
      acc_r   <= {DATA_WIDTH{1'b0}};
      ovf_r   <= 1'b0;
      cnt_r   <= {COUNT_WIDTH{1'b0}};
      len_q_r <= bus.cfg_len;
    end else if (beat_s) begin
      acc_r <= sum_s;
      ovf_r <= ovf_r | carry_s;
      cnt_r <= cnt_r + CNT_ONE;
    end else begin
      acc_r   <= acc_r;
      ovf_r   <= ovf_r;
      cnt_r   <= cnt_r;
      len_q_r <= len_q_r;
    end
  end

  assign bus.in_ready  = (state_r == ST_ACCUM);
  assign bus.out_valid = (state_r == ST_DONE);
  assign bus.busy      = (state_r == ST_ACCUM) || (state_r == ST_DONE);
  assign bus.out_acc   = acc_r;
  assign bus.out_ovf   = ovf_r;

endmodule

// File: tb/tb_sum_accumulator_32bit.sv
// Directed, table-driven bench for sum_accumulator_32bit plus hand sequences for
// reset, backpressure, full-length, ignored-start and flush corner cases.
module tb_sum_accumulator_32bit;
  localparam int DW = 32;
  localparam int CW = 8;

  typedef struct packed {
    logic [7:0]       len;
    logic [3:0][31:0] sums;
    logic [31:0]      exp_acc;
    logic             exp_ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sum_accumulator_32bit_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) bus ();

  sum_accumulator_32bit #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [6];

  function automatic vec_t mk(input logic [7:0] len, input logic [31:0] s0, input logic [31:0] s1,
                              input logic [31:0] s2, input logic [31:0] s3,
                              input logic [31:0] ea, input logic eo);
    vec_t v;
    v.len = len;
    v.sums[0] = s0;
    v.sums[1] = s1;
    v.sums[2] = s2;
    v.sums[3] = s3;
    v.exp_acc = ea;
    v.exp_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start     = 1'b0;
    bus.cfg_len   = 8'd0;
    bus.flush     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sum    = 32'd0;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input bit gaps);
    bus.start   = 1'b1;
    bus.cfg_len = v.len;
    step();
    bus.start = 1'b0;
    chk("accum_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("accum_busy", {31'd0, bus.busy}, 32'd1);
    for (int i = 0; i < int'(v.len); i++) begin
      if (gaps) begin
        bus.in_valid = 1'b0;
        bus.in_sum   = 32'hDEADBEEF;
        step();
        chk("gap_no_done", {31'd0, bus.out_valid}, 32'd0);
      end
      bus.in_valid = 1'b1;
      bus.in_sum   = v.sums[i];
      step();
      chk("beat_out_valid", {31'd0, bus.out_valid}, (i == int'(v.len) - 1) ? 32'd1 : 32'd0);
    end
    bus.in_valid = 1'b0;
    chk("vec_acc", bus.out_acc, v.exp_acc);
    chk("vec_ovf", {31'd0, bus.out_ovf}, {31'd0, v.exp_ovf});
    chk("done_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("taken_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("taken_busy", {31'd0, bus.busy}, 32'd0);
    chk("taken_acc_held", bus.out_acc, v.exp_acc);
  endtask

  initial begin
    vecs[0] = mk(8'd3, 32'h10, 32'h20, 32'h30, 32'h0, 32'h60, 1'b0);
    vecs[1] = mk(8'd2, 32'hFFFFFFF0, 32'h20, 32'h0, 32'h0, 32'h10, 1'b1);
    vecs[2] = mk(8'd1, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h12345678, 1'b0);
    vecs[3] = mk(8'd4, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 32'h0, 1'b1);
    vecs[4] = mk(8'd3, 32'hFFFFFFFF, 32'h1, 32'h5, 32'h0, 32'h5, 1'b1);
    vecs[5] = mk(8'd2, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 32'h80000000, 1'b0);

    idle_inputs();
    #12;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_acc", bus.out_acc, 32'd0);
    chk("rst_out_ovf", {31'd0, bus.out_ovf}, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    step();

    // Data presented in IDLE must be ignored
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'h55;
    step();
    bus.in_valid = 1'b0;
    chk("idle_no_accept", bus.out_acc, 32'd0);
    chk("idle_stays", {31'd0, bus.busy}, 32'd0);

    for (int k = 0; k < 6; k++) begin
      run_vec(vecs[k], (k == 1));
    end

    // Asynchronous reset in the middle of an accumulation
    bus.start   = 1'b1;
    bus.cfg_len = 8'd4;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'h0000_0100;
    step();
    step();
    bus.in_valid = 1'b0;
    chk("pre_rst_acc", bus.out_acc, 32'h200);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("arst_out_acc", bus.out_acc, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    run_vec(vecs[0], 1'b0);

    // Backpressure with gapped input and a consumer holding off for 5 cycles
    bus.start   = 1'b1;
    bus.cfg_len = 8'd2;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'h100;
    step();
    bus.in_valid = 1'b0;
    bus.in_sum   = 32'h999;
    step();
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'h200;
    step();
    bus.in_sum = 32'hFFFF;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_acc", bus.out_acc, 32'h300);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_taken", {31'd0, bus.out_valid}, 32'd0);
    chk("bp_idle_ready", {31'd0, bus.in_ready}, 32'd0);

    // Zero length means 256 beats
    bus.start   = 1'b1;
    bus.cfg_len = 8'd0;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'd1;
    for (int b = 1; b <= 255; b++) begin
      step();
    end
    chk("full_255_not_done", {31'd0, bus.out_valid}, 32'd0);
    chk("full_255_acc", bus.out_acc, 32'd255);
    step();
    bus.in_valid = 1'b0;
    chk("full_256_done", {31'd0, bus.out_valid}, 32'd1);
    chk("full_256_acc", bus.out_acc, 32'h100);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;

    // Start during ACCUM is ignored; flush with start and out_ready in DONE discards the result
    bus.start   = 1'b1;
    bus.cfg_len = 8'd3;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'd5;
    step();
    bus.start   = 1'b1;
    bus.cfg_len = 8'd1;
    bus.in_sum  = 32'd6;
    step();
    bus.start = 1'b0;
    chk("ign_start_not_done", {31'd0, bus.out_valid}, 32'd0);
    chk("ign_start_acc", bus.out_acc, 32'd11);
    bus.in_sum = 32'd7;
    step();
    bus.in_valid = 1'b0;
    chk("ign_start_done", {31'd0, bus.out_valid}, 32'd1);
    chk("ign_start_total", bus.out_acc, 32'd18);
    bus.flush     = 1'b1;
    bus.start     = 1'b1;
    bus.out_ready = 1'b1;
    step();
    idle_inputs();
    chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_busy", {31'd0, bus.busy}, 32'd0);
    chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("flush_acc", bus.out_acc, 32'd0);
    step();
    chk("flush_start_ignored", {31'd0, bus.busy}, 32'd0);

    // Flush in the middle of ACCUM clears the partial total
    bus.start   = 1'b1;
    bus.cfg_len = 8'd3;
    step();
    bus.start    = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_sum   = 32'hFFFFFFFF;
    step();
    bus.in_sum = 32'h2;
    step();
    chk("mid_ovf_set", {31'd0, bus.out_ovf}, 32'd1);
    bus.flush = 1'b1;
    step();
    idle_inputs();
    chk("mid_flush_acc", bus.out_acc, 32'd0);
    chk("mid_flush_ovf", {31'd0, bus.out_ovf}, 32'd0);
    chk("mid_flush_busy", {31'd0, bus.busy}, 32'd0);
    run_vec(vecs[2], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
